regfile_write_sequencer: RTL and testbench
==========================================

REGFILE_WRITE_SEQUENCER -- requirements
Module: regfile_write_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, giving the request FIFO depth in entries (legal range 2..4).
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port clr_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1 bit: a write request is present.
REQ-005 SHALL have port req_ready, output, 1 bit: the FIFO can accept a request.
REQ-006 SHALL have port req_addr, input, 5 bits: target register R0..R31.
REQ-007 SHALL have port req_wide, input, 1 bit: 1 = 16-bit register-pair write, 0 = byte write.
REQ-008 SHALL have port req_data, input, 16 bits: write data; only [7:0] used when req_wide=0.
REQ-009 SHALL have port WA, output, 5 bits: register file write address.
REQ-010 SHALL have port WD, output, 8 bits: register file write data.
REQ-011 SHALL have port RegWrite, output, 1 bit: register file write enable.
REQ-012 SHALL have port busy, output, 1 bit: FIFO non-empty or a byte write in progress.
REQ-013 SHALL have port err_align, output, 1 bit: one-cycle pulse on an odd-address wide request.

Function
REQ-014 SHALL accept a request on a rising edge when req_valid=1 and req_ready=1; req_ready = (FIFO count < DEPTH).
REQ-015 SHALL ignore req_valid while req_ready=0, with no FIFO or output change.
REQ-016 SHALL force req_addr[0] to 0 for wide requests at acceptance and pulse err_align high for the following cycle.
REQ-017 SHALL implement FSM states IDLE (RegWrite=0), LO (RegWrite=1, WA=addr, WD=data[7:0]) and HI (RegWrite=1, WA=addr+1, WD=data[15:8]).
REQ-018 SHALL transition from LO to HI when the current entry is wide.
REQ-019 SHALL otherwise pop the FIFO head into LO if the FIFO is non-empty, else go to IDLE.
REQ-020 SHALL drive WA, WD and RegWrite from registers (no combinational path from req_* inputs).
REQ-021 SHALL have a latency such that a request accepted at edge E into an empty, idle block has RegWrite=1 from edge E+1; the high byte follows at E+2.
REQ-022 SHALL sustain one byte write per cycle: back-to-back byte requests produce consecutive RegWrite cycles with no bubble.
REQ-023 SHALL count a pop and a push on the same edge as a net-zero count change; the push is legal only when count < DEPTH before the edge.
REQ-024 SHALL never wrap addresses: the maximum wide address is 30, so HI writes at most R31.
REQ-025 SHALL set busy = (state != IDLE) or (count != 0).

Reset
REQ-026 SHALL, while clr_n=0, immediately force: FIFO count 0, state IDLE, RegWrite 0, WA 0, WD 0, err_align 0, req_ready 0.
REQ-027 SHALL set req_ready to 1 on the first clock edge after clr_n is released.
REQ-028 SHALL discard pending requests on reset mid-operation; if reset asserts while in HI, the high byte is not written and no partial write resumes afterwards.

Structure
REQ-029 SHALL take the FSM state encodings (IDLE=0, LO=1, HI=2) and the DEPTH default from the shared CPU package/include.
REQ-030 SHALL implement the FIFO as one sub-module, sync_fifo_req, of width 22 (addr, wide, data) with count/full/empty outputs and the same clock and clr_n.

Verification
REQ-031 Byte write: req addr=5, wide=0, data=0x00A7 -> a single RegWrite cycle with WA=5, WD=0xA7; busy returns to 0 next cycle.
REQ-032 Pair write: addr=24, wide=1, data=0xBEEF -> WA=24/WD=0xEF, then WA=25/WD=0xBE in consecutive cycles.
REQ-033 Misaligned pair write: addr=27, wide=1, data=0x1234 -> err_align pulses once; writes go to R26=0x34 and R27=0x12.
REQ-034 Backpressure: hold req_valid with 3 wide requests, DEPTH=2 -> req_ready drops at count 2; all 6 bytes are written in order with no request loss.
REQ-035 Reset mid-pair: assert clr_n=0 during the HI cycle of addr=30 -> RegWrite drops immediately; R31 is not written; idle after release.

Source files
------------

// File: rtl/regfile_write_sequencer_pkg.sv
// Shared types for the register-file write sequencer.
// State encodings, request entry layout and default FIFO depth.
package regfile_write_sequencer_pkg;

    localparam int DEPTH_DEFAULT = 2;
    localparam int REQ_W         = 22;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_e;

    typedef struct packed {
        logic [4:0]  addr;
        logic        wide;
        logic [15:0] data;
    } req_t;

    // Wide writes target an even/odd pair, so the low bit is dropped.
    function automatic req_t align_req(
        input logic [4:0]  addr,
        input logic        wide,
        input logic [15:0] data
    );
        req_t r;
        r.addr = wide ? {addr[4:1], 1'b0} : addr;
        r.wide = wide;
        r.data = data;
        return r;
    endfunction

endpackage

// File: rtl/regfile_write_sequencer_fifo.sv
// Show-ahead request FIFO for the write sequencer.
// Head entry is visible combinationally; push and pop may share an edge.
module sync_fifo_req #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 22,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             clr_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; simultaneous push/pop nets to zero.
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/regfile_write_sequencer.sv
// Register-file write sequencer: queues byte/pair write requests
// and replays them as one registered byte write per cycle.
module regfile_write_sequencer
    import regfile_write_sequencer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic        clock,
    input  logic        clr_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_addr,
    input  logic        req_wide,
    input  logic [15:0] req_data,
    output logic [4:0]  WA,
    output logic [7:0]  WD,
    output logic        RegWrite,
    output logic        busy,
    output logic        err_align
);

    localparam int CW = $clog2(DEPTH + 1);

    state_e        state_q;
    req_t          cur_q;
    logic [4:0]    wa_q;
    logic [7:0]    wd_q;
    logic          we_q;
    logic          rdy_q;
    logic          err_q;

    req_t          req_d;
    req_t          head;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          hi_next;

    assign req_d     = align_req(req_addr, req_wide, req_data);
    assign req_ready = rdy_q && !full;
    assign push      = req_valid && req_ready;
    assign hi_next   = (state_q == LO) && cur_q.wide;
    assign pop       = !empty && !hi_next;

    assign WA        = wa_q;
    assign WD        = wd_q;
    assign RegWrite  = we_q;
    assign err_align = err_q;
    assign busy      = (state_q != IDLE) || (count != '0);

    sync_fifo_req #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clock   (clock),
        .clr_n   (clr_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (req_d),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // Hold off acceptance until the first edge after reset release.
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // One-cycle alignment error pulse for odd-address pair requests.
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= push && req_wide && req_addr[0];
        end
    end

    // Write FSM: low byte, optional high byte, then next queued entry.
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            if (hi_next) begin
                state_q <= HI;
                wa_q    <= cur_q.addr + 5'd1;
                wd_q    <= cur_q.data[15:8];
                we_q    <= 1'b1;
            end else if (!empty) begin
                state_q <= LO;
                cur_q   <= head;
                wa_q    <= head.addr;
                wd_q    <= head.data[7:0];
                we_q    <= 1'b1;
            end else begin
                state_q <= IDLE;
                we_q    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Scoreboard bench for the register-file write sequencer.
// Expected byte writes are queued at request time and matched on RegWrite.
module tb_regfile_write_sequencer;

    logic        clock;
    logic        clr_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_addr;
    logic        req_wide;
    logic [15:0] req_data;
    logic [4:0]  WA;
    logic [7:0]  WD;
    logic        RegWrite;
    logic        busy;
    logic        err_align;

    int n_chk;
    int n_fail;
    int cyc;
    logic saw_nr;

    logic [12:0] exp_q [$];
    int          wr_cyc [$];

    regfile_write_sequencer #(.DEPTH(2)) dut (
        .clock     (clock),
        .clr_n     (clr_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wide  (req_wide),
        .req_data  (req_data),
        .WA        (WA),
        .WD        (WD),
        .RegWrite  (RegWrite),
        .busy      (busy),
        .err_align (err_align)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (clr_n && RegWrite) begin
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {27'd0, WA}, 32'h0);
            end else begin
                logic [12:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", int'(WA), int'(e[12:8]));
                chk("wr_data", int'(WD), int'(e[7:0]));
            end
        end
    end

    task automatic send(input logic [4:0] a, input logic w,
                        input logic [15:0] d, input logic skip_hi);
        logic [4:0] al;
        int n;
        @(negedge clock);
        req_valid = 1'b1;
        req_addr  = a;
        req_wide  = w;
        req_data  = d;
        n = 0;
        while (!req_ready && n < 50) begin
            saw_nr = 1'b1;
            @(negedge clock);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 1, 0);
        al = w ? {a[4:1], 1'b0} : a;
        exp_q.push_back({al, d[7:0]});
        if (w && !skip_hi) exp_q.push_back({al + 5'd1, d[15:8]});
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        chk("err_align", int'(err_align), int'(w & a[0]));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        saw_nr = 1'b0;
        clr_n = 1'b0;
        req_valid = 1'b0;
        req_addr = '0;
        req_wide = 1'b0;
        req_data = '0;
        tick(2);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_we", int'(RegWrite), 0);
        chk("rst_wa", int'(WA), 0);
        chk("rst_wd", int'(WD), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err_align), 0);
        @(negedge clock);
        clr_n = 1'b1;
        tick(1);
        chk("ready_after_rst", int'(req_ready), 1);

        // single byte write and its latency
        send(5'd5, 1'b0, 16'h00A7, 1'b0);
        tick(1);
        chk("byte_we", int'(RegWrite), 1);
        chk("byte_wa", int'(WA), 5);
        chk("byte_wd", int'(WD), 8'hA7);
        tick(1);
        chk("byte_we_off", int'(RegWrite), 0);
        chk("byte_busy_off", int'(busy), 0);

        // aligned pair
        send(5'd24, 1'b1, 16'hBEEF, 1'b0);
        tick(1);
        chk("pair_lo_wa", int'(WA), 24);
        tick(1);
        chk("pair_hi_wa", int'(WA), 25);
        chk("pair_hi_wd", int'(WD), 8'hBE);
        tick(2);

        // misaligned pair
        send(5'd27, 1'b1, 16'h1234, 1'b0);
        tick(1);
        chk("err_pulse_end", int'(err_align), 0);
        tick(3);

        // backpressure with three pair requests and a trailing byte
        saw_nr = 1'b0;
        send(5'd2, 1'b1, 16'h1111, 1'b0);
        send(5'd10, 1'b1, 16'h2222, 1'b0);
        send(5'd20, 1'b1, 16'h3333, 1'b0);
        chk("bp_ready_low", int'(req_ready), 0);
        chk("bp_busy", int'(busy), 1);
        send(5'd12, 1'b0, 16'h0055, 1'b0);
        chk("bp_saw_stall", int'(saw_nr), 1);
        tick(10);
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_ready_back", int'(req_ready), 1);

        // back-to-back bytes without bubbles
        send(5'd1, 1'b0, 16'h0011, 1'b0);
        send(5'd2, 1'b0, 16'h0022, 1'b0);
        send(5'd3, 1'b0, 16'h0033, 1'b0);
        tick(4);
        begin
            int n;
            n = wr_cyc.size();
            chk("burst_span", wr_cyc[n-1] - wr_cyc[n-3], 2);
        end

        // reset during the high-byte cycle of a pair at R30
        send(5'd30, 1'b1, 16'hCAFE, 1'b0);
        void'(exp_q.pop_back());
        tick(1);
        chk("rst_pair_lo", int'(WA), 30);
        tick(1);
        chk("rst_pair_hi_wa", int'(WA), 31);
        chk("rst_pair_hi_we", int'(RegWrite), 1);
        clr_n = 1'b0;
        #1;
        chk("rst_mid_we", int'(RegWrite), 0);
        chk("rst_mid_ready", int'(req_ready), 0);
        chk("rst_mid_busy", int'(busy), 0);
        tick(2);
        @(negedge clock);
        clr_n = 1'b1;
        tick(1);
        chk("rst_mid_ready_back", int'(req_ready), 1);
        tick(4);
        chk("rst_mid_idle_we", int'(RegWrite), 0);
        chk("rst_mid_idle_busy", int'(busy), 0);
        chk("final_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
